chain_eval_sequencer: RTL and testbench



---
 rtl/chain_eval_sequencer_pkg.sv | 23 ++
 rtl/chain_eval_sequencer_if.sv | 28 ++
 rtl/chain_eval_sequencer_stage.sv | 15 +
 rtl/chain_eval_sequencer.sv | 112 +++++++++++
 tb/tb_chain_eval_sequencer.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/chain_eval_sequencer_pkg.sv
// Shared types, constants and the closed-form reference for the XOR/NOT chain sequencer.
// The closed form also backs the optional CHAIN_EVAL_CHECK_EN self-check.
package chain_eval_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DONE_CNT_W = 16;
  localparam int CF_W       = 64;

  // Net effect of 'depth' stages: even bits flip on odd depths; odd bits pick up
  // the even bit on odd depths and flip whenever depth[1] is set.
  function automatic logic [CF_W-1:0] closed_form(input logic [CF_W-1:0] data,
                                                  input logic [31:0] depth);
    logic [CF_W-1:0] r;
    r = '0;
    for (int j = 0; j < CF_W/2; j++) begin
      r[2*j]   = data[2*j] ^ depth[0];
      r[2*j+1] = data[2*j+1] ^ (data[2*j] & depth[0]) ^ depth[1];
    end
    return r;
  endfunction

endpackage

// File: rtl/chain_eval_sequencer_if.sv
// Request/response handshake bundle between the stimulus source and the chain sequencer.
interface chain_eval_sequencer_if #(
  parameter int IO_PAIRS  = 5,
  parameter int DEPTH_MAX = 16
);
  localparam int DW = 2*IO_PAIRS;
  localparam int CW = $clog2(DEPTH_MAX+1) + 1;

  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_data;
  logic [CW-1:0] req_depth;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    output req_valid, req_data, req_depth, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_data, req_depth, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/chain_eval_sequencer_stage.sv
// One combinational stage of IO_PAIRS XOR/NOT primitive pairs (odd ^= even, even = ~even).
module xor_not_stage #(
  parameter int IO_PAIRS = 5,
  parameter int DW       = 2*IO_PAIRS
) (
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  for (genvar gi = 0; gi < IO_PAIRS; gi++) begin : g_pair
    assign dout[2*gi]   = ~din[2*gi];
    assign dout[2*gi+1] = din[2*gi+1] ^ din[2*gi];
  end

endmodule

// File: rtl/chain_eval_sequencer.sv
// Time-multiplexed XOR/NOT chain evaluator: one shared stage iterated once per clock.
// Optional CHAIN_EVAL_CHECK_EN adds chk_mismatch, comparing the result to the closed form.
module chain_eval_sequencer
  import chain_eval_pkg::*;
#(
  parameter int IO_PAIRS  = 5,
  parameter int DEPTH_MAX = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  chain_eval_sequencer_if.slave bus,
  output logic                  busy,
  output logic [DONE_CNT_W-1:0] done_count
`ifdef CHAIN_EVAL_CHECK_EN
  ,
  output logic                  chk_mismatch
`endif
);

  localparam int DW = 2*IO_PAIRS;
  localparam int CW = $clog2(DEPTH_MAX+1) + 1;

  state_t                state_reg, state_next;
  logic [DW-1:0]         data_reg, data_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic                  err_reg, err_next;
  logic [DONE_CNT_W-1:0] done_count_reg, done_count_next;
  logic [DW-1:0]         stage_out;
  logic                  over_range;
  logic [CW-1:0]         depth_eff;

  xor_not_stage #(.IO_PAIRS(IO_PAIRS), .DW(DW)) u_stage (
    .din  (data_reg),
    .dout (stage_out)
  );

  assign over_range = bus.req_depth > CW'(DEPTH_MAX);
  assign depth_eff  = over_range ? CW'(DEPTH_MAX) : bus.req_depth;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      data_reg       <= '0;
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
      done_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      data_reg       <= data_next;
      cnt_reg        <= cnt_next;
      err_reg        <= err_next;
      done_count_reg <= done_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    data_next       = data_reg;
    cnt_next        = cnt_reg;
    err_next        = err_reg;
    done_count_next = done_count_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          data_next  = bus.req_data;
          cnt_next   = depth_eff;
          err_next   = over_range;
          state_next = (depth_eff == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        data_next = stage_out;
        cnt_next  = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) state_next = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) begin
          done_count_next = done_count_reg + DONE_CNT_W'(1);
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == DONE);
  assign bus.rsp_data  = data_reg;
  assign bus.rsp_err   = err_reg;
  assign busy          = (state_reg != IDLE);
  assign done_count    = done_count_reg;

`ifdef CHAIN_EVAL_CHECK_EN
  // Only depth[1:0] matters to the closed form, so two bits of depth are kept.
  logic [DW-1:0] in_reg;
  logic [1:0]    dlow_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_reg   <= '0;
      dlow_reg <= '0;
    end else if (state_reg == IDLE && bus.req_valid) begin
      in_reg   <= bus.req_data;
      dlow_reg <= depth_eff[1:0];
    end
  end

  assign chk_mismatch = (state_reg == DONE) &&
    (|((closed_form(CF_W'(in_reg), 32'(dlow_reg)) ^ CF_W'(data_reg)) & CF_W'({DW{1'b1}})));
`endif

endmodule

// File: tb/tb_chain_eval_sequencer.sv
// Directed bench for chain_eval_sequencer; CHAIN_EVAL_CHECK_EN also enables a random closed-form sweep.
module tb_chain_eval_sequencer;
  import chain_eval_pkg::*;

  localparam int IO_PAIRS  = 5;
  localparam int DEPTH_MAX = 16;
  localparam int DW        = 2*IO_PAIRS;
  localparam int CW        = $clog2(DEPTH_MAX+1) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] done_count;
`ifdef CHAIN_EVAL_CHECK_EN
  logic        chk_mismatch;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  chain_eval_sequencer_if #(.IO_PAIRS(IO_PAIRS), .DEPTH_MAX(DEPTH_MAX)) bus_if ();

  chain_eval_sequencer #(.IO_PAIRS(IO_PAIRS), .DEPTH_MAX(DEPTH_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .busy       (busy),
    .done_count (done_count)
`ifdef CHAIN_EVAL_CHECK_EN
    ,
    .chk_mismatch (chk_mismatch)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the response and complete the handshake.
  // hold > 0 keeps rsp_ready low that many cycles in DONE while a stray request is offered.
  task automatic run_job(input string tag, input logic [DW-1:0] data, input logic [CW-1:0] depth,
                         input logic [DW-1:0] exp_data, input logic exp_err, input int exp_lat,
                         input int hold);
    int lat;
    check_eq({tag, "_req_ready"}, 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_data  = data;
    bus_if.req_depth = depth;
    bus_if.rsp_ready = (hold == 0);
    tick();
    bus_if.req_valid = 1'b0;
    lat = 0;
    while (!bus_if.rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_rsp_data"}, 32'(bus_if.rsp_data), 32'(exp_data));
    check_eq({tag, "_rsp_err"}, 32'(bus_if.rsp_err), 32'(exp_err));
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
`ifdef CHAIN_EVAL_CHECK_EN
    check_eq({tag, "_chk_mismatch"}, 32'(chk_mismatch), 32'd0);
`endif
    for (int i = 0; i < hold; i++) begin
      bus_if.req_valid = 1'b1;
      bus_if.req_data  = ~data;
      bus_if.req_depth = CW'(1);
      tick();
      check_eq({tag, "_hold_valid"}, 32'(bus_if.rsp_valid), 32'd1);
      check_eq({tag, "_hold_data"}, 32'(bus_if.rsp_data), 32'(exp_data));
      check_eq({tag, "_hold_req_ready"}, 32'(bus_if.req_ready), 32'd0);
      check_eq({tag, "_hold_count"}, 32'(done_count), 32'(exp_cnt));
    end
    bus_if.req_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    tick();
    exp_cnt = (exp_cnt + 1) & 32'hFFFF;
    check_eq({tag, "_after_valid"}, 32'(bus_if.rsp_valid), 32'd0);
    check_eq({tag, "_after_req_ready"}, 32'(bus_if.req_ready), 32'd1);
    check_eq({tag, "_done_count"}, 32'(done_count), 32'(exp_cnt));
    $display("job %s: data=0x%03h depth=%0d -> rsp=0x%03h err=%0d lat=%0d count=%0d",
             tag, data, depth, bus_if.rsp_data, bus_if.rsp_err, lat, done_count);
  endtask

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_data  = '0;
    bus_if.req_depth = '0;
    bus_if.rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(bus_if.rsp_data), 32'd0);
    check_eq("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done_count", 32'(done_count), 32'd0);
    rst_n = 1'b1;

    // Reset during RUN (depth 10, fourth stage cycle).
    bus_if.req_valid = 1'b1;
    bus_if.req_data  = 10'h000;
    bus_if.req_depth = CW'(10);
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.req_valid = 1'b0;
    tick();
    tick();
    tick();
    check_eq("midrun_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrun_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check_eq("midrun_req_ready", 32'(bus_if.req_ready), 32'd1);
    check_eq("midrun_busy_after", 32'(busy), 32'd0);
    check_eq("midrun_rsp_data", 32'(bus_if.rsp_data), 32'd0);
    check_eq("midrun_done_count", 32'(done_count), 32'd0);
    $display("job midrun_reset: depth=10 aborted, count=%0d", done_count);

    run_job("d10",    10'h000, CW'(10), 10'h2AA, 1'b0, 10, 0);
    run_job("d1",     10'h000, CW'(1),  10'h155, 1'b0, 1,  0);
    run_job("d2",     10'h000, CW'(2),  10'h2AA, 1'b0, 2,  0);
    run_job("d3",     10'h000, CW'(3),  10'h3FF, 1'b0, 3,  0);
    run_job("d0",     10'h3A5, CW'(0),  10'h3A5, 1'b0, 0,  0);
    run_job("d20",    10'h3A5, CW'(20), 10'h3A5, 1'b1, 16, 0);
    run_job("d5",     10'h3A5, CW'(5),  10'h0FA, 1'b0, 5,  0);
    run_job("d16",    10'h155, CW'(16), 10'h155, 1'b0, 16, 0);
    run_job("d17",    10'h155, CW'(17), 10'h155, 1'b1, 16, 0);
    run_job("d4hold", 10'h0F0, CW'(4),  10'h0F0, 1'b0, 4,  5);

`ifdef CHAIN_EVAL_CHECK_EN
    for (int k = 0; k < 200; k++) begin
      logic [DW-1:0]   rd;
      logic [CW-1:0]   rdep;
      int              deff;
      logic [CF_W-1:0] cf;
      rd   = DW'($urandom);
      rdep = CW'($urandom_range(0, 20));
      deff = (int'(rdep) > DEPTH_MAX) ? DEPTH_MAX : int'(rdep);
      cf   = closed_form(CF_W'(rd), 32'(deff));
      run_job($sformatf("rnd%0d", k), rd, rdep, cf[DW-1:0], int'(rdep) > DEPTH_MAX, deff, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
